// File: rtl/instruction_loader_pkg.sv
// rtl/instruction_loader_pkg.sv - shared types and constants for the instruction loader
package instruction_loader_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECEIVE = 2'd1,
      DONE    = 2'd2
   } loader_state_t;

   localparam int          NB_BYTE   = 8;
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   // Ceiling log2, shared with the fetch and memory blocks for address sizing.
   function automatic int clogb2(input int value);
      int result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// rtl/instruction_loader_byte_assembler.sv - big-endian byte to word assembler
module instruction_loader_byte_assembler
   import instruction_loader_pkg::*;
#(
   parameter int NB_INSTR = 32,
   parameter int NB_BYTE  = instruction_loader_pkg::NB_BYTE
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_clear,
   input  logic [NB_BYTE-1:0]  i_rx_data,
   input  logic                i_rx_valid,
   output logic [NB_INSTR-1:0] o_word,
   output logic                o_word_ready
);

   // Only the first three bytes need holding; the fourth goes straight into o_word.
   logic [NB_INSTR-NB_BYTE-1:0] shift_reg;
   logic [1:0]                  byte_count;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         shift_reg    <= '0;
         byte_count   <= '0;
         o_word       <= '0;
         o_word_ready <= 1'b0;
      end else begin
         o_word_ready <= 1'b0;
         if (i_clear) begin
            shift_reg  <= '0;
            byte_count <= '0;
         end else if (i_rx_valid) begin
            shift_reg  <= {shift_reg[NB_INSTR-2*NB_BYTE-1:0], i_rx_data};
            byte_count <= byte_count + 2'd1;
            if (byte_count == 2'd3) begin
               o_word       <= {shift_reg, i_rx_data};
               o_word_ready <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - loads UART program bytes into instruction memory
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int                  NB_INSTR  = 32,
   parameter int                  NB_REG    = 32,
   parameter int                  NB_BYTE   = instruction_loader_pkg::NB_BYTE,
   parameter int                  N_ADDR    = 2048,
   parameter logic [NB_INSTR-1:0] HALT_WORD = instruction_loader_pkg::HALT_WORD
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [NB_BYTE-1:0]  i_rx_data,
   input  logic                i_rx_valid,
   output logic [NB_INSTR-1:0] o_wr_data,
   output logic [NB_REG-1:0]   o_wr_addr,
   output logic                o_wr_enable,
   output logic                o_loading,
   output logic                o_done,
   output logic                o_error
);

   // One extra bit so the count can reach N_ADDR without wrapping.
   localparam int                 NB_WCNT   = clogb2(N_ADDR) + 1;
   localparam logic [NB_WCNT-1:0] LAST_WORD = NB_WCNT'(N_ADDR - 1);

   loader_state_t      state;
   logic [NB_WCNT-1:0] word_count;

   instruction_loader_byte_assembler #(
      .NB_INSTR (NB_INSTR),
      .NB_BYTE  (NB_BYTE)
   ) u_byte_assembler (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_clear      (i_start),
      .i_rx_data    (i_rx_data),
      .i_rx_valid   (i_rx_valid && (state == RECEIVE)),
      .o_word       (o_wr_data),
      .o_word_ready (o_wr_enable)
   );

   // word_count still holds the index of the word being written during the write cycle.
   assign o_wr_addr = NB_REG'({word_count, 2'b00});

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state      <= IDLE;
         word_count <= '0;
         o_loading  <= 1'b0;
         o_done     <= 1'b0;
         o_error    <= 1'b0;
      end else if (i_start) begin
         state      <= RECEIVE;
         word_count <= '0;
         o_loading  <= 1'b1;
         o_done     <= 1'b0;
         o_error    <= 1'b0;
      end else if (state == RECEIVE && o_wr_enable) begin
         word_count <= word_count + NB_WCNT'(1);
         if (o_wr_data == HALT_WORD) begin
            state     <= DONE;
            o_loading <= 1'b0;
            o_done    <= 1'b1;
         end else if (word_count == LAST_WORD) begin
            state     <= DONE;
            o_loading <= 1'b0;
            o_done    <= 1'b1;
            o_error   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - directed self-checking bench for instruction_loader
module tb_instruction_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;

   logic [31:0] wr_data, s_wr_data;
   logic [31:0] wr_addr, s_wr_addr;
   logic        wr_enable, s_wr_enable;
   logic        loading, s_loading;
   logic        done, s_done;
   logic        error, s_error;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instruction_loader dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_start     (start),
      .i_rx_data   (rx_data),
      .i_rx_valid  (rx_valid),
      .o_wr_data   (wr_data),
      .o_wr_addr   (wr_addr),
      .o_wr_enable (wr_enable),
      .o_loading   (loading),
      .o_done      (done),
      .o_error     (error)
   );

   instruction_loader #(.N_ADDR(4)) dut_small (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_start     (start),
      .i_rx_data   (rx_data),
      .i_rx_valid  (rx_valid),
      .o_wr_data   (s_wr_data),
      .o_wr_addr   (s_wr_addr),
      .o_wr_enable (s_wr_enable),
      .o_loading   (s_loading),
      .o_done      (s_done),
      .o_error     (s_error)
   );

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #2;
      // Reset state
      do_reset();
      chk("rst_wr_enable", wr_enable, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_loading", loading, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      send_byte(8'h55);
      chk("idle_ignores_rx", wr_enable, 0);

      // Test 1: single word
      do_start();
      chk("t1_loading", loading, 1);
      send_byte(8'h8C); chk("t1_no_wr_b0", wr_enable, 0);
      send_byte(8'h01); chk("t1_no_wr_b1", wr_enable, 0);
      send_byte(8'h00); chk("t1_no_wr_b2", wr_enable, 0);
      send_byte(8'h04);
      chk("t1_wr_enable", wr_enable, 1);
      chk("t1_wr_data", wr_data, 32'h8C01_0004);
      chk("t1_wr_addr", wr_addr, 0);
      chk("t1_loading_w", loading, 1);
      tick();
      chk("t1_wr_pulse", wr_enable, 0);

      // Test 2: back-to-back words ending with halt
      do_reset();
      do_start();
      send_word(32'hA1B2_C3D4);
      chk("t2_w0_data", wr_data, 32'hA1B2_C3D4);
      chk("t2_w0_addr", wr_addr, 0);
      send_word(32'h1122_3344);
      chk("t2_w1_en", wr_enable, 1);
      chk("t2_w1_data", wr_data, 32'h1122_3344);
      chk("t2_w1_addr", wr_addr, 4);
      send_word(32'hFFFF_FFFF);
      chk("t2_halt_en", wr_enable, 1);
      chk("t2_halt_data", wr_data, 32'hFFFF_FFFF);
      chk("t2_halt_addr", wr_addr, 8);
      tick();
      chk("t2_done", done, 1);
      chk("t2_loading", loading, 0);
      chk("t2_error", error, 0);
      for (int i = 0; i < 4; i++) begin
         send_byte(8'h10 + 8'(i));
         chk("t2_done_ignores_rx", wr_enable, 0);
      end
      tick();
      chk("t2_done_ignores_rx_end", wr_enable, 0);

      // Test 3: gapped bytes, one arriving in the write cycle
      do_reset();
      do_start();
      send_byte(8'h00); repeat (6) tick();
      send_byte(8'h00); repeat (6) tick();
      send_byte(8'h00); repeat (6) tick();
      send_byte(8'h20);
      chk("t3_w0_en", wr_enable, 1);
      chk("t3_w0_data", wr_data, 32'h0000_0020);
      chk("t3_w0_addr", wr_addr, 0);
      send_byte(8'h12); repeat (6) tick();
      send_byte(8'h34); repeat (6) tick();
      send_byte(8'h56); repeat (6) tick();
      send_byte(8'h78);
      chk("t3_w1_en", wr_enable, 1);
      chk("t3_w1_data", wr_data, 32'h1234_5678);
      chk("t3_w1_addr", wr_addr, 4);

      // Test 4: small memory fills before halt
      do_reset();
      do_start();
      for (int i = 0; i < 4; i++) begin
         send_word(32'h0102_0304 + 32'(i));
         chk("t4_en", s_wr_enable, 1);
         chk("t4_data", s_wr_data, 32'h0102_0304 + 32'(i));
         chk("t4_addr", s_wr_addr, 32'(i * 4));
      end
      tick();
      chk("t4_error", s_error, 1);
      chk("t4_done", s_done, 1);
      chk("t4_loading", s_loading, 0);
      for (int i = 0; i < 4; i++) begin
         send_byte(8'hA0);
         chk("t4_no_5th_write", s_wr_enable, 0);
      end
      tick();
      chk("t4_no_5th_write_end", s_wr_enable, 0);

      // Test 6: reload from DONE clears error
      do_start();
      chk("t6_error_clr", s_error, 0);
      chk("t6_done_clr", s_done, 0);
      chk("t6_loading", s_loading, 1);
      send_word(32'hDEAD_BEEF);
      chk("t6_en", s_wr_enable, 1);
      chk("t6_data", s_wr_data, 32'hDEAD_BEEF);
      chk("t6_addr", s_wr_addr, 0);

      // Test 5: reset mid-word
      do_reset();
      do_start();
      send_byte(8'h99);
      send_byte(8'h88);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_wr_enable", wr_enable, 0);
      chk("t5_loading", loading, 0);
      chk("t5_done", done, 0);
      chk("t5_error", error, 0);
      chk("t5_wr_data", wr_data, 0);
      chk("t5_wr_addr", wr_addr, 0);
      send_byte(8'h77);
      send_byte(8'h66);
      chk("t5_idle_no_wr", wr_enable, 0);
      do_start();
      send_word(32'hCAFE_BABE);
      chk("t5_en", wr_enable, 1);
      chk("t5_data", wr_data, 32'hCAFE_BABE);
      chk("t5_addr", wr_addr, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
